fifo_packetizer: RTL



---
 rtl/fifo_packetizer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fifo_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_packetizer
//  Description : Drains a first-word-fall-through FIFO into a local burst
//                buffer and emits length-prefixed packets (one count header
//                word, then the buffered payload with last on the final word)
//                on a valid/ready stream. A packet closes when the buffer is
//                full, on an idle timeout, or on an explicit flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_packetizer #(
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_BURST     = 16,
  parameter int COUNT_WIDTH   = 5,
  parameter int TIMEOUT       = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  output logic                  o_read_en,
  input  logic                  i_flush,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_last,
  output logic                  o_busy
);

  // Buffer is addressed with just enough bits for MAX_BURST entries.
  localparam int c_IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int c_DEPTH = 1 << c_IDX_W;
  localparam int c_TLAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

  localparam logic [COUNT_WIDTH-1:0]   c_MAX        = COUNT_WIDTH'(MAX_BURST);
  localparam logic [TIMEOUT_WIDTH-1:0] c_TIMER_LAST = TIMEOUT_WIDTH'(c_TLAST);
  localparam logic                     c_TIMEOUT_EN = (TIMEOUT != 0);

  localparam logic [1:0] c_COLLECT = 2'd0;
  localparam logic [1:0] c_HEADER  = 2'd1;
  localparam logic [1:0] c_PAYLOAD = 2'd2;

  logic [1:0]               r_state;
  logic [1:0]               w_state_next;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic [COUNT_WIDTH-1:0]   r_idx;
  logic [TIMEOUT_WIDTH-1:0] r_timer;
  logic [DATA_WIDTH-1:0]    r_buf [c_DEPTH];

  logic                     w_pop;
  logic [COUNT_WIDTH-1:0]   w_count_next;
  logic                     w_timeout_hit;
  logic                     w_close;
  logic                     w_last;

  // Reset gates the pop so the FIFO is never read while held in reset.
  assign w_pop         = reset & (r_state == c_COLLECT) & ~i_fifo_empty & (r_count < c_MAX);
  assign w_count_next  = r_count + COUNT_WIDTH'(w_pop);
  // Timer reaches TIMEOUT-1 after TIMEOUT idle cycles following the last pop.
  assign w_timeout_hit = c_TIMEOUT_EN & ~w_pop & (r_count != '0) & (r_timer == c_TIMER_LAST);
  // Flush only closes a non-empty packet, so empty packets never go out.
  assign w_close       = (w_count_next == c_MAX) | (i_flush & (w_count_next != '0)) | w_timeout_hit;
  assign w_last        = (r_idx == (r_count - COUNT_WIDTH'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; flush is only observed while collecting.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_COLLECT: if (w_close)               w_state_next = c_HEADER;
      c_HEADER:  if (i_out_ready)           w_state_next = c_PAYLOAD;
      c_PAYLOAD: if (i_out_ready && w_last) w_state_next = c_COLLECT;
      default:                              w_state_next = c_COLLECT;
    endcase
  end

  // Word count, idle timer and payload index bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_timer <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        c_COLLECT: begin
          if (w_pop) begin
            r_count <= w_count_next;
            r_timer <= '0;
          end else if ((r_count != '0) && (r_timer != c_TIMER_LAST)) begin
            r_timer <= r_timer + TIMEOUT_WIDTH'(1);
          end
        end
        c_HEADER: begin
          if (i_out_ready) r_idx <= '0;
        end
        c_PAYLOAD: begin
          if (i_out_ready) begin
            if (w_last) begin
              r_count <= '0;
              r_timer <= '0;
            end else begin
              r_idx <= r_idx + COUNT_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Payload buffer captures the FWFT head word in the cycle it is popped.
  always_ff @(posedge clk) begin
    if (w_pop) r_buf[r_count[c_IDX_W-1:0]] <= i_read_data;
  end

  // Output decode; data and last are forced to zero whenever not valid.
  always_comb begin
    o_read_en   = w_pop;
    o_out_valid = 1'b0;
    o_out_data  = '0;
    o_out_last  = 1'b0;
    o_busy      = 1'b0;
    if (reset) begin
      case (r_state)
        c_HEADER: begin
          o_out_valid = 1'b1;
          o_out_data  = DATA_WIDTH'(r_count);
          o_busy      = 1'b1;
        end
        c_PAYLOAD: begin
          o_out_valid = 1'b1;
          o_out_data  = r_buf[r_idx[c_IDX_W-1:0]];
          o_out_last  = w_last;
          o_busy      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
